// File: rtl/cache_1_pkg.sv
// rtl/cache_1_pkg.sv - shared constants, state codes and tag-compare helper for the L1 tag controller
package cache_1_pkg;

    localparam int CACHE_AWIDTH = 3;
    localparam int CACHE_TWIDTH = 13;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT    = 3'd0;
    localparam state_t ST_IDLE    = 3'd1;
    localparam state_t ST_LOOKUP  = 3'd2;
    localparam state_t ST_COMPARE = 3'd3;
    localparam state_t ST_REFILL  = 3'd4;
    localparam state_t ST_UPDATE  = 3'd5;
    localparam state_t ST_INVAL   = 3'd6;

    // A tag RAM entry is {valid, tag}.
    function automatic int entry_width(input int twidth);
        return twidth + 1;
    endfunction

    // Tags are zero-extended to 32 bits by the caller so any TWIDTH up to 32 fits.
    function automatic logic tag_match(input logic valid, input logic [31:0] stored,
                                       input logic [31:0] want);
        return valid && (stored == want);
    endfunction

endpackage

// File: rtl/cache_1_stat_ctr.sv
// rtl/cache_1_stat_ctr.sv - saturating event counter with increment enable
module cache_1_stat_ctr #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count up on each enable, holding once all ones is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/cache_1_tag_ctrl.sv
// rtl/cache_1_tag_ctrl.sv - direct-mapped L1 tag controller; CACHE_1_TAG_STATS_EN adds hit/miss counters
module cache_1_tag_ctrl
    import cache_1_pkg::*;
#(
    parameter int AWIDTH = CACHE_AWIDTH,
    parameter int TWIDTH = CACHE_TWIDTH,
    parameter int STAT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cpu_req,
    input  logic                     cpu_op,
    input  logic [TWIDTH+AWIDTH-1:0] cpu_addr,
    output logic                     cpu_ready,
    output logic                     cpu_done,
    output logic                     cpu_hit,
    output logic [AWIDTH-1:0]        tag_addr,
    output logic [TWIDTH:0]          tag_wdata,
    output logic                     tag_we,
    input  logic [TWIDTH:0]          tag_rdata,
    output logic                     mem_req,
    output logic [TWIDTH+AWIDTH-1:0] mem_addr,
    input  logic                     mem_ack,
    output logic [STAT_W-1:0]        hit_count,
    output logic [STAT_W-1:0]        miss_count
);

    localparam int DWIDTH    = entry_width(TWIDTH);
    localparam int VALID_BIT = DWIDTH - 1;
    localparam logic [AWIDTH-1:0] LAST_IDX = {AWIDTH{1'b1}};

    state_t                     state_q, state_d;
    logic [AWIDTH-1:0]          init_cnt_q, init_cnt_d;
    logic [TWIDTH+AWIDTH-1:0]   addr_q, addr_d;

    logic [AWIDTH-1:0]          req_idx;
    logic [TWIDTH-1:0]          req_tag;
    logic                       hit;

    assign req_idx = addr_q[AWIDTH-1:0];
    assign req_tag = addr_q[TWIDTH+AWIDTH-1:AWIDTH];
    assign hit     = tag_match(tag_rdata[VALID_BIT], 32'(tag_rdata[TWIDTH-1:0]), 32'(req_tag));

    // Next-state logic: init sweep, request dispatch, compare and refill sequencing.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        addr_d     = addr_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    state_d = cpu_op ? ST_INVAL : ST_LOOKUP;
                end
            end
            ST_LOOKUP:  state_d = ST_COMPARE;
            ST_COMPARE: state_d = hit ? ST_IDLE : ST_REFILL;
            ST_REFILL: begin
                if (mem_ack) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE:  state_d = ST_IDLE;
            ST_INVAL:   state_d = ST_IDLE;
            default:    state_d = ST_INIT;
        endcase
    end

    // State, sweep counter and latched request address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            addr_q     <= addr_d;
        end
    end

    // Outputs decoded from state; the write strobe is held low while reset is asserted
    // so the sweep's first write lands on the first clock after release.
    always_comb begin
        cpu_ready = (state_q == ST_IDLE);
        cpu_hit   = (state_q == ST_COMPARE) && hit;
        cpu_done  = cpu_hit || (state_q == ST_UPDATE) || (state_q == ST_INVAL);
        tag_we    = reset_n && ((state_q == ST_INIT) || (state_q == ST_UPDATE) ||
                                (state_q == ST_INVAL));
        tag_addr  = (state_q == ST_INIT) ? init_cnt_q : req_idx;
        tag_wdata = (state_q == ST_UPDATE) ? {1'b1, req_tag} : '0;
        mem_req   = (state_q == ST_REFILL);
        mem_addr  = addr_q;
    end

`ifdef CACHE_1_TAG_STATS_EN
    logic hit_inc;
    logic miss_inc;

    assign hit_inc  = (state_q == ST_COMPARE) && hit;
    assign miss_inc = (state_q == ST_COMPARE) && !hit;

    cache_1_stat_ctr #(.W(STAT_W)) u_hit_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (hit_inc),
        .count_o (hit_count)
    );

    cache_1_stat_ctr #(.W(STAT_W)) u_miss_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (miss_inc),
        .count_o (miss_count)
    );
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_1_tag_ctrl.sv
// tb/tb_cache_1_tag_ctrl.sv - scoreboard bench for cache_1_tag_ctrl with tag RAM and refill responder models
module tb_cache_1_tag_ctrl;

    localparam int AW    = 3;
    localparam int TW    = 13;
    localparam int DW    = TW + 1;
    localparam int DEPTH = 1 << AW;
`ifdef CACHE_1_TAG_STATS_EN
    localparam int SW = 2;
`else
    localparam int SW = 16;
`endif

    logic              clock;
    logic              reset_n;
    logic              cpu_req;
    logic              cpu_op;
    logic [TW+AW-1:0]  cpu_addr;
    logic              cpu_ready;
    logic              cpu_done;
    logic              cpu_hit;
    logic [AW-1:0]     tag_addr;
    logic [DW-1:0]     tag_wdata;
    logic              tag_we;
    logic [DW-1:0]     tag_rdata;
    logic              mem_req;
    logic [TW+AW-1:0]  mem_addr;
    logic              mem_ack;
    logic [SW-1:0]     hit_count;
    logic [SW-1:0]     miss_count;

    cache_1_tag_ctrl #(.AWIDTH(AW), .TWIDTH(TW), .STAT_W(SW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_op     (cpu_op),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_done   (cpu_done),
        .cpu_hit    (cpu_hit),
        .tag_addr   (tag_addr),
        .tag_wdata  (tag_wdata),
        .tag_we     (tag_we),
        .tag_rdata  (tag_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Tag RAM: synchronous write, registered-address read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clock) begin
        if (tag_we) ram[tag_addr] <= tag_wdata;
        tag_rdata <= ram[tag_addr];
    end

    typedef struct {
        bit              op;
        bit              hit;
        logic [TW+AW-1:0] addr;
        logic [DW-1:0]   wdata;
        int              req_cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model: per-line valid/tag and event totals.
    bit              mv [DEPTH];
    logic [TW-1:0]   mt [DEPTH];
    int              model_hits;
    int              model_misses;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_delay = 3;
    bit hold_ack  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = 0;
            mt[i] = '0;
        end
        model_hits   = 0;
        model_misses = 0;
    endtask

    function automatic int sat(input int v);
        int lim = (1 << SW) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk_counters();
`ifdef CACHE_1_TAG_STATS_EN
        chk("hit_count", hit_count, sat(model_hits));
        chk("miss_count", miss_count, sat(model_misses));
`else
        chk("hit_count_tied", hit_count, 0);
        chk("miss_count_tied", miss_count, 0);
`endif
    endtask

    // Called at the negedge where reset is released: expects DEPTH sweep writes, then ready.
    task automatic check_init();
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("init_we", tag_we, 1);
            chk("init_addr", tag_addr, i);
            chk("init_wdata", tag_wdata, 0);
            chk("init_ready", cpu_ready, 0);
            @(negedge clock);
        end
        #1;
        chk("init_done_ready", cpu_ready, 1);
        chk("init_done_we", tag_we, 0);
    endtask

    // Issue one request at a negedge; optionally wait (with busy-time noise) until idle again.
    task automatic issue(input bit op, input logic [TW+AW-1:0] addr, input bit finish);
        exp_t e;
        int idx = int'(addr) % DEPTH;
        logic [TW-1:0] tg = TW'(int'(addr) / DEPTH);
        int guard = 0;
        bit done_wait = 0;
        while (!cpu_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (!cpu_ready) begin
            fail_now("ready_timeout");
            return;
        end
        e.op = op;
        e.addr = addr;
        e.req_cyc = cyc;
        if (!op) begin
            e.hit = mv[idx] && (mt[idx] == tg);
            if (e.hit) begin
                model_hits++;
                e.wdata = '0;
            end else begin
                model_misses++;
                mv[idx] = 1;
                mt[idx] = tg;
                e.wdata = DW'((1 << TW) + int'(tg));
            end
        end else begin
            e.hit = 0;
            mv[idx] = 0;
            e.wdata = '0;
        end
        sb.push_back(e);
        cpu_req = 1'b1;
        cpu_op = op;
        cpu_addr = addr;
        @(posedge clock);
        #1;
        cpu_req = 1'b0;
        cpu_op = 1'($urandom);
        cpu_addr = (TW+AW)'($urandom);
        if (finish) begin
            guard = 0;
            while (!done_wait) begin
                @(negedge clock);
                if (cpu_ready) begin
                    cpu_req = 1'b0;
                    done_wait = 1;
                end else begin
                    cpu_req = 1'($urandom);
                    cpu_op = 1'($urandom);
                    cpu_addr = (TW+AW)'($urandom);
                    guard++;
                    if (guard > 100) begin
                        fail_now("op_timeout");
                        done_wait = 1;
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
    endtask

    // Monitor: every completion pulse is matched against the oldest expected response.
    exp_t m;
    always @(negedge clock) begin
        if (reset_n && cpu_done) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                m = sb.pop_front();
                chk("done_hit", cpu_hit, m.hit);
                if (!m.op && m.hit) begin
                    // done lands in the third cycle counting the accepting IDLE cycle
                    chk("hit_latency", cyc - m.req_cyc, 2);
                    chk("hit_no_write", tag_we, 0);
                end else begin
                    chk("wr_en", tag_we, 1);
                    chk("wr_addr", tag_addr, int'(m.addr) % DEPTH);
                    chk("wr_data", tag_wdata, m.wdata);
                end
            end
        end
    end

    // Next-level memory responder: acks each refill after a delay.
    initial begin
        int d;
        mem_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n && mem_req && !hold_ack) begin
                if (sb.size() == 0 || sb[0].op || sb[0].hit) begin
                    fail_now("spurious_mem_req");
                end else begin
                    chk("mem_addr", mem_addr, sb[0].addr);
                end
                d = (ack_delay < 0) ? int'($urandom_range(0, 4)) : ack_delay;
                repeat (d) @(negedge clock);
                mem_ack = 1'b1;
                @(negedge clock);
                mem_ack = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [TW+AW-1:0] a;
        reset_n = 1'b0;
        cpu_req = 1'b0;
        cpu_op = 1'b0;
        cpu_addr = '0;
        model_clear();
        #1;
        chk("rst_ready", cpu_ready, 0);
        chk("rst_done", cpu_done, 0);
        chk("rst_hit", cpu_hit, 0);
        chk("rst_we", tag_we, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk_counters();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        check_init();

        // Directed sequence on index 5.
        ack_delay = 3;
        issue(0, 16'hABCD, 1);
        chk("ram5_after_fill", ram[5], 14'h3579);
        issue(0, 16'hABCD, 1);
        issue(0, 16'h1235, 1);
        chk("ram5_after_conflict", ram[5], 14'h2246);
        issue(0, 16'hABCD, 1);
        issue(1, 16'hABCD, 1);
        chk("ram5_after_inval", ram[5], 14'h0000);
        issue(0, 16'hABCD, 1);
        repeat (4) issue(0, 16'hABCD, 1);
        drain();
        chk_counters();

        // Randomized traffic over a small tag pool so hits, conflicts and invalidates mix.
        ack_delay = -1;
        for (int n = 0; n < 80; n++) begin
            a = {TW'($urandom_range(0, 2) * 13'h0555 + 13'h0101), AW'($urandom_range(0, DEPTH - 1))};
            issue(($urandom_range(0, 5) == 0), a, 1);
        end
        drain();
        chk_counters();

        // Reset asserted while a refill is outstanding.
        issue(1, 16'h0003, 1);
        drain();
        hold_ack = 1;
        issue(0, 16'h0003, 0);
        guard = 0;
        while (!mem_req && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        chk("refill_reached", mem_req, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_ready", cpu_ready, 0);
        chk("rst_mid_done", cpu_done, 0);
        chk("rst_mid_we", tag_we, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        sb.delete();
        model_clear();
        chk_counters();
        hold_ack = 0;
        ack_delay = 2;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        check_init();
        issue(0, 16'h0003, 1);
        issue(0, 16'h0003, 1);
        drain();
        chk_counters();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
